// File: rtl/alu_pkg.sv
// Shared ALU constants: opcode encodings, opcode width and the sequencer state encoding.
package alu_pkg;

  localparam int NB_OP = 6;

  localparam logic [NB_OP-1:0] OP_ADD = 6'b100000;
  localparam logic [NB_OP-1:0] OP_SUB = 6'b100010;
  localparam logic [NB_OP-1:0] OP_AND = 6'b100100;
  localparam logic [NB_OP-1:0] OP_OR  = 6'b100101;
  localparam logic [NB_OP-1:0] OP_XOR = 6'b100110;
  localparam logic [NB_OP-1:0] OP_SRA = 6'b000011;
  localparam logic [NB_OP-1:0] OP_SRL = 6'b000010;
  localparam logic [NB_OP-1:0] OP_NOR = 6'b100111;

  localparam logic [2:0] ST_LOAD_A  = 3'd0;
  localparam logic [2:0] ST_LOAD_B  = 3'd1;
  localparam logic [2:0] ST_LOAD_OP = 3'd2;
  localparam logic [2:0] ST_WAIT    = 3'd3;
  localparam logic [2:0] ST_RESULT  = 3'd4;

endpackage

// File: rtl/alu_op_check.sv
// Combinational legal-opcode decoder; used by alu_sequencer only when ALU_SEQ_OPCHK_EN is defined.
module alu_op_check
  import alu_pkg::*;
(
  input  logic [NB_OP-1:0] i_op,
  output logic             o_legal
);

  always_comb begin
    case (i_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_SRA, OP_SRL, OP_NOR: o_legal = 1'b1;
      default:                        o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Byte-stream front end for the 8-bit ALU: loads A, B, opcode, waits RESULT_LAT, returns result.
// Define ALU_SEQ_OPCHK_EN to reject illegal opcodes with o_res_err instead of forwarding them.
module alu_sequencer #(
  parameter int NB_DATA    = 8,
  parameter int RESULT_LAT = 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_flush,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_data,
  output logic               o_ready,
  output logic [NB_DATA-1:0] o_alu_data,
  output logic               o_alu_enable_1,
  output logic               o_alu_enable_2,
  output logic               o_alu_enable_3,
  input  logic [NB_DATA-1:0] i_alu_data,
  input  logic               i_alu_carry,
  input  logic               i_alu_zero,
  output logic               o_res_valid,
  input  logic               i_res_ready,
  output logic [NB_DATA-1:0] o_res_data,
  output logic               o_res_carry,
  output logic               o_res_zero,
  output logic               o_res_err,
  output logic [2:0]         o_dbg_state
);
  import alu_pkg::*;

  // Both ports transfer on the edge where valid & ready are high; valid never waits on ready.
  logic [2:0]         r_state;
  logic [2:0]         w_next_state;
  logic               r_ready;
  logic [NB_DATA-1:0] r_alu_data;
  logic               r_en_1, r_en_2, r_en_3;
  logic [3:0]         r_cnt;
  logic               r_res_valid;
  logic [NB_DATA-1:0] r_res_data;
  logic               r_res_carry, r_res_zero, r_res_err;
  logic               w_accept;
  logic               w_handshake;
  logic               w_op_legal;

  assign w_accept    = i_valid & r_ready;
  assign w_handshake = r_res_valid & i_res_ready;

`ifdef ALU_SEQ_OPCHK_EN
  alu_op_check u_op_check (
    .i_op    (i_data[NB_OP-1:0]),
    .o_legal (w_op_legal)
  );
`else
  assign w_op_legal = 1'b1;
`endif

  always_comb begin
    w_next_state = r_state;
    if (i_flush) begin
      w_next_state = ST_LOAD_A;
    end else begin
      case (r_state)
        ST_LOAD_A:  if (w_accept) w_next_state = ST_LOAD_B;
        ST_LOAD_B:  if (w_accept) w_next_state = ST_LOAD_OP;
        ST_LOAD_OP: if (w_accept) w_next_state = w_op_legal ? ST_WAIT : ST_RESULT;
        ST_WAIT:    if (r_cnt == 4'd0) w_next_state = ST_RESULT;
        ST_RESULT:  if (w_handshake) w_next_state = ST_LOAD_A;
        default:    w_next_state = ST_LOAD_A;
      endcase
    end
  end

  // o_ready is registered so it stays low while reset is asserted.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= ST_LOAD_A;
      r_ready     <= 1'b0;
      r_alu_data  <= '0;
      r_en_1      <= 1'b0;
      r_en_2      <= 1'b0;
      r_en_3      <= 1'b0;
      r_cnt       <= 4'd0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_carry <= 1'b0;
      r_res_zero  <= 1'b0;
      r_res_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_ready <= (w_next_state == ST_LOAD_A) || (w_next_state == ST_LOAD_B) ||
                 (w_next_state == ST_LOAD_OP);
      r_en_1  <= 1'b0;
      r_en_2  <= 1'b0;
      r_en_3  <= 1'b0;
      if (w_accept && !i_flush) begin
        r_alu_data <= i_data;
        r_en_1     <= (r_state == ST_LOAD_A);
        r_en_2     <= (r_state == ST_LOAD_B);
        r_en_3     <= (r_state == ST_LOAD_OP) && w_op_legal;
      end
      if (i_flush) begin
        r_cnt       <= 4'd0;
        r_res_valid <= 1'b0;
        r_res_data  <= '0;
        r_res_carry <= 1'b0;
        r_res_zero  <= 1'b0;
        r_res_err   <= 1'b0;
      end else begin
        case (r_state)
          ST_LOAD_OP: begin
            if (w_accept && w_op_legal) begin
              r_cnt <= 4'(RESULT_LAT);
            end else if (w_accept) begin
              r_res_valid <= 1'b1;
              r_res_data  <= '0;
              r_res_carry <= 1'b0;
              r_res_zero  <= 1'b0;
              r_res_err   <= 1'b1;
            end
          end
          ST_WAIT: begin
            if (r_cnt == 4'd0) begin
              r_res_valid <= 1'b1;
              r_res_data  <= i_alu_data;
              r_res_carry <= i_alu_carry;
              r_res_zero  <= i_alu_zero;
              r_res_err   <= 1'b0;
            end else begin
              r_cnt <= r_cnt - 4'd1;
            end
          end
          ST_RESULT: if (w_handshake) r_res_valid <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  // A flush also kills an enable pulse already in flight this cycle.
  assign o_alu_enable_1 = r_en_1 & ~i_flush;
  assign o_alu_enable_2 = r_en_2 & ~i_flush;
  assign o_alu_enable_3 = r_en_3 & ~i_flush;
  assign o_ready        = r_ready;
  assign o_alu_data     = r_alu_data;
  assign o_res_valid    = r_res_valid;
  assign o_res_data     = r_res_data;
  assign o_res_carry    = r_res_carry;
  assign o_res_zero     = r_res_zero;
  assign o_res_err      = r_res_err;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural ALU model and a result scoreboard.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       i_reset, i_flush, i_valid, i_res_ready;
  logic [7:0] i_data;
  logic       o_ready;
  logic [7:0] o_alu_data;
  logic       o_alu_enable_1, o_alu_enable_2, o_alu_enable_3;
  logic [7:0] i_alu_data;
  logic       i_alu_carry, i_alu_zero;
  logic       o_res_valid;
  logic [7:0] o_res_data;
  logic       o_res_carry, o_res_zero, o_res_err;
  logic [2:0] o_dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [10:0] exp_q[$];
  logic [5:0]  legal_ops[8] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR};

  alu_sequencer #(.NB_DATA(8), .RESULT_LAT(1)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_flush(i_flush), .i_valid(i_valid), .i_data(i_data),
    .o_ready(o_ready), .o_alu_data(o_alu_data), .o_alu_enable_1(o_alu_enable_1),
    .o_alu_enable_2(o_alu_enable_2), .o_alu_enable_3(o_alu_enable_3), .i_alu_data(i_alu_data),
    .i_alu_carry(i_alu_carry), .i_alu_zero(i_alu_zero), .o_res_valid(o_res_valid),
    .i_res_ready(i_res_ready), .o_res_data(o_res_data), .o_res_carry(o_res_carry),
    .o_res_zero(o_res_zero), .o_res_err(o_res_err), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural ALU ----------------
  function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      OP_ADD:  return {1'b0, a} + {1'b0, b};
      OP_SUB:  return {1'b0, a} - {1'b0, b};
      OP_AND:  return {1'b0, a & b};
      OP_OR:   return {1'b0, a | b};
      OP_XOR:  return {1'b0, a ^ b};
      OP_NOR:  return {1'b0, ~(a | b)};
      OP_SRA:  return {1'b0, 8'($signed(a) >>> b[2:0])};
      OP_SRL:  return {1'b0, a >> b[2:0]};
      default: return 9'h000;
    endcase
  endfunction

  logic [7:0] m_a = '0, m_b = '0;
  logic [5:0] m_op = '0;
  logic [8:0] m_res;
  always @(posedge clk) begin
    if (o_alu_enable_1) m_a <= o_alu_data;
    if (o_alu_enable_2) m_b <= o_alu_data;
    if (o_alu_enable_3) m_op <= o_alu_data[5:0];
  end
  assign m_res       = alu_ref(m_a, m_b, m_op);
  assign i_alu_data  = m_res[7:0];
  assign i_alu_carry = m_res[8];
  assign i_alu_zero  = (m_res[7:0] == 8'h00);

  // {err, carry, zero, data}
  logic [10:0] res_vec;
  assign res_vec = {o_res_err, o_res_carry, o_res_zero, o_res_data};
  logic [14:0] all_out;
  assign all_out = {o_ready, o_alu_enable_1, o_alu_enable_2, o_alu_enable_3, o_res_valid, o_res_carry,
                    o_res_zero, o_res_err, o_dbg_state, 4'h0} | {7'h0, o_alu_data} | {7'h0, o_res_data};

`ifdef ALU_SEQ_OPCHK_EN
  function automatic bit is_legal(input logic [5:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction
`endif

  function automatic logic [10:0] exp_of(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    logic [8:0] r;
`ifdef ALU_SEQ_OPCHK_EN
    if (!is_legal(op[5:0])) return 11'h400;
`endif
    r = alu_ref(a, b, op[5:0]);
    return {1'b0, r[8], (r[7:0] == 8'h00), r[7:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op, input bit push);
    logic [7:0] bytes[3];
    bytes = '{a, b, op};
    for (int i = 0; i < 3; i++) begin
      i_valid = 1'b1;
      i_data  = bytes[i];
      for (int k = 0; k < 20 && !o_ready; k++) step();
      step();
    end
    i_valid = 1'b0;
    if (push) exp_q.push_back(exp_of(a, b, op));
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (o_res_valid) begin
        ok = 1'b1;
        return;
      end
      step();
    end
  endtask

  task automatic pop_exp(output logic [10:0] e);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 'x;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_reset = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_data = '0; i_res_ready = 1'b1;
    step(); step();
    n_tests++; if (all_out !== 15'h0) begin n_fail++; $display("FAIL reset_outputs got=%h exp=0", all_out); end
    i_reset = 1'b1;
    #1;
    n_tests++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_before_edge got=%b exp=0", o_ready); end
    step();
    n_tests++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after got=%b exp=1", o_ready); end
    n_tests++; if (o_dbg_state !== ST_LOAD_A) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", o_dbg_state, ST_LOAD_A); end
  endtask

  task automatic test_basic();
    logic [10:0] e;
    i_valid = 1'b1; i_data = 8'h05; step();
    n_tests++; if ({o_alu_enable_1, o_alu_enable_2, o_alu_enable_3, o_alu_data} !== {3'b100, 8'h05})
      begin n_fail++; $display("FAIL basic_load_a got=%b/%h exp=100/05", {o_alu_enable_1, o_alu_enable_2, o_alu_enable_3}, o_alu_data); end
    i_data = 8'h03; step();
    n_tests++; if ({o_alu_enable_1, o_alu_enable_2, o_alu_enable_3, o_alu_data} !== {3'b010, 8'h03})
      begin n_fail++; $display("FAIL basic_load_b got=%b/%h exp=010/03", {o_alu_enable_1, o_alu_enable_2, o_alu_enable_3}, o_alu_data); end
    i_data = 8'h20; exp_q.push_back(exp_of(8'h05, 8'h03, 8'h20)); step();
    i_valid = 1'b0;
    n_tests++; if ({o_alu_enable_1, o_alu_enable_2, o_alu_enable_3, o_ready, o_res_valid} !== 5'b00100)
      begin n_fail++; $display("FAIL basic_load_op got=%b exp=00100", {o_alu_enable_1, o_alu_enable_2, o_alu_enable_3, o_ready, o_res_valid}); end
    step();
    n_tests++; if ({o_alu_enable_3, o_res_valid} !== 2'b00) begin n_fail++; $display("FAIL basic_wait got=%b exp=00", {o_alu_enable_3, o_res_valid}); end
    step();
    pop_exp(e);
    n_tests++; if (o_res_valid !== 1'b1 || res_vec !== 11'h008) begin n_fail++; $display("FAIL basic_result_t3 got=%b/%h exp=1/008", o_res_valid, res_vec); end
    n_tests++; if (res_vec !== e) begin n_fail++; $display("FAIL basic_scoreboard got=%h exp=%h", res_vec, e); end
    step();
    n_tests++; if ({o_res_valid, o_ready} !== 2'b01) begin n_fail++; $display("FAIL basic_after_hs got=%b exp=01", {o_res_valid, o_ready}); end
  endtask

  task automatic test_carry_zero();
    logic [10:0] e;
    bit ok;
    drive_op(8'hFF, 8'h01, {2'b00, OP_ADD}, 1'b1);
    wait_valid(ok); pop_exp(e);
    n_tests++; if (!ok || res_vec !== 11'h300 || res_vec !== e) begin n_fail++; $display("FAIL add_carry got=%h exp=300 sb=%h ok=%b", res_vec, e, ok); end
    step();
    drive_op(8'h05, 8'h05, {2'b00, OP_SUB}, 1'b1);
    wait_valid(ok); pop_exp(e);
    n_tests++; if (!ok || res_vec[8:0] !== 9'h100 || res_vec !== e) begin n_fail++; $display("FAIL sub_zero got=%h exp=x100 sb=%h ok=%b", res_vec, e, ok); end
    step();
  endtask

  task automatic test_backpressure();
    logic [10:0] e, snap;
    bit ok, stable;
    i_res_ready = 1'b0;
    drive_op(8'h0A, 8'h14, {2'b00, OP_ADD}, 1'b1);
    wait_valid(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL bp_timeout got=no_valid exp=valid"); end
    snap = res_vec;
    i_valid = 1'b1; i_data = 8'h07;
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (res_vec !== snap || o_res_valid !== 1'b1 || o_ready !== 1'b0 || o_alu_enable_1 !== 1'b0) stable = 1'b0;
      step();
    end
    n_tests++; if (!stable) begin n_fail++; $display("FAIL bp_stable got=%h/%b/%b exp=%h/1/0", res_vec, o_res_valid, o_ready, snap); end
    pop_exp(e);
    n_tests++; if (res_vec !== 11'h01E || res_vec !== e) begin n_fail++; $display("FAIL bp_result got=%h exp=01E sb=%h", res_vec, e); end
    i_res_ready = 1'b1;
    step();
    n_tests++; if ({o_res_valid, o_ready, o_alu_enable_1} !== 3'b010) begin n_fail++; $display("FAIL bp_after_hs got=%b exp=010", {o_res_valid, o_ready, o_alu_enable_1}); end
    step();
    n_tests++; if ({o_alu_enable_1, o_alu_data} !== {1'b1, 8'h07}) begin n_fail++; $display("FAIL bp_next_a got=%b/%h exp=1/07", o_alu_enable_1, o_alu_data); end
    i_data = 8'h01; step();
    i_data = {2'b00, OP_OR}; exp_q.push_back(exp_of(8'h07, 8'h01, {2'b00, OP_OR})); step();
    i_valid = 1'b0;
    wait_valid(ok); pop_exp(e);
    n_tests++; if (!ok || res_vec !== e) begin n_fail++; $display("FAIL bp_followup got=%h exp=%h ok=%b", res_vec, e, ok); end
    step();
  endtask

  task automatic test_flush();
    logic [10:0] e;
    bit ok, seen;
    i_valid = 1'b1; i_data = 8'h11; step();
    i_flush = 1'b1; i_data = 8'h99;
    #1;
    n_tests++; if (o_alu_enable_1 !== 1'b0) begin n_fail++; $display("FAIL flush_en_suppress got=%b exp=0", o_alu_enable_1); end
    step();
    i_flush = 1'b0; i_valid = 1'b0;
    n_tests++; if ({o_dbg_state, o_ready, o_alu_data} !== {ST_LOAD_A, 1'b1, 8'h11})
      begin n_fail++; $display("FAIL flush_state got=%0d/%b/%h exp=0/1/11", o_dbg_state, o_ready, o_alu_data); end
    drive_op(8'h02, 8'h03, 8'h20, 1'b1);
    wait_valid(ok); pop_exp(e);
    n_tests++; if (!ok || res_vec !== 11'h005 || res_vec !== e) begin n_fail++; $display("FAIL flush_restart got=%h exp=005 sb=%h", res_vec, e); end
    step();
    // flush while a result is waiting for the consumer
    i_res_ready = 1'b0;
    drive_op(8'h30, 8'h0F, {2'b00, OP_AND}, 1'b0);
    wait_valid(ok);
    i_flush = 1'b1; step(); i_flush = 1'b0;
    i_res_ready = 1'b1;
    n_tests++; if ({o_res_valid, o_ready, o_dbg_state} !== {2'b01, ST_LOAD_A}) begin n_fail++; $display("FAIL flush_result got=%b/%b/%0d exp=0/1/0", o_res_valid, o_ready, o_dbg_state); end
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin if (o_res_valid) seen = 1'b1; step(); end
    n_tests++; if (seen) begin n_fail++; $display("FAIL flush_stale got=valid exp=no_valid"); end
  endtask

  task automatic test_illegal_op();
    logic [10:0] e;
    i_valid = 1'b1; i_data = 8'h01; step();
    i_data = 8'h02; step();
    i_data = 8'h3F; exp_q.push_back(exp_of(8'h01, 8'h02, 8'h3F)); step();
    i_valid = 1'b0;
`ifdef ALU_SEQ_OPCHK_EN
    n_tests++; if ({o_alu_enable_3, o_res_valid} !== 2'b01) begin n_fail++; $display("FAIL illegal_timing got=%b exp=01", {o_alu_enable_3, o_res_valid}); end
    pop_exp(e);
    n_tests++; if (res_vec !== 11'h400 || res_vec !== e) begin n_fail++; $display("FAIL illegal_err got=%h exp=400 sb=%h", res_vec, e); end
`else
    n_tests++; if ({o_alu_enable_3, o_res_valid} !== 2'b10) begin n_fail++; $display("FAIL illegal_fwd_en3 got=%b exp=10", {o_alu_enable_3, o_res_valid}); end
    step(); step();
    pop_exp(e);
    n_tests++; if (o_res_valid !== 1'b1 || o_res_err !== 1'b0 || res_vec !== e) begin n_fail++; $display("FAIL illegal_fwd_res got=%b/%h exp=1/%h", o_res_valid, res_vec, e); end
`endif
    step();
  endtask

  task automatic test_reset_mid_wait();
    bit seen;
    drive_op(8'h09, 8'h04, {2'b00, OP_XOR}, 1'b0);
    n_tests++; if (o_dbg_state !== ST_WAIT) begin n_fail++; $display("FAIL rst_wait_entry got=%0d exp=%0d", o_dbg_state, ST_WAIT); end
    #1; i_reset = 1'b0; #1;
    n_tests++; if (all_out !== 15'h0) begin n_fail++; $display("FAIL rst_wait_outputs got=%h exp=0", all_out); end
    step();
    i_reset = 1'b1;
    n_tests++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL rst_wait_ready0 got=%b exp=0", o_ready); end
    step();
    n_tests++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL rst_wait_ready1 got=%b exp=1", o_ready); end
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin if (o_res_valid) seen = 1'b1; step(); end
    n_tests++; if (seen) begin n_fail++; $display("FAIL rst_wait_stale got=valid exp=no_valid"); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] e;
    logic [7:0]  a, b;
    logic [5:0]  op;
    int start, d;
    bit ok;
    for (int n = 0; n < 12; n++) begin
      a  = 8'($urandom_range(0, 255));
      b  = 8'($urandom_range(0, 255));
      op = legal_ops[$urandom_range(0, 7)];
      i_res_ready = 1'b0;
      start = cyc;
      drive_op(a, b, {2'b00, op}, 1'b1);
      wait_valid(ok);
      n_tests++; if (!ok || (cyc - start) !== 5) begin n_fail++; $display("FAIL b2b_latency n=%0d got=%0d exp=5 ok=%b", n, cyc - start, ok); end
      d = $urandom_range(0, 3);
      repeat (d) step();
      i_res_ready = 1'b1;
      pop_exp(e);
      n_tests++; if (o_res_valid !== 1'b1 || res_vec !== e) begin n_fail++; $display("FAIL b2b_result n=%0d a=%h b=%h op=%h got=%h exp=%h", n, a, b, op, res_vec, e); end
      step();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_carry_zero();
    test_backpressure();
    test_flush();
    test_illegal_op();
    test_reset_mid_wait();
    test_back_to_back();
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
